// File: rtl/clock_pkg.sv
// Shared definitions for the clock-setting and timekeeping blocks:
// field widths, legal ranges, the setter's state encoding, and the packed
// time-of-day record.
package clock_pkg;

   localparam int HOUR_W = 4;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   localparam logic [HOUR_W-1:0] HOUR_MIN = 4'd1;
   localparam logic [HOUR_W-1:0] HOUR_MAX = 4'd12;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

   // Setter FSM encoding; anything other than INITIAL means an edit is in progress.
   localparam logic [1:0] SET_INITIAL = 2'd0;
   localparam logic [1:0] SET_PM      = 2'd1;
   localparam logic [1:0] SET_HOUR    = 2'd2;
   localparam logic [1:0] SET_MINUTE  = 2'd3;

   typedef struct packed {
      logic              is_pm;
      logic [HOUR_W-1:0] hours;
      logic [MIN_W-1:0]  minutes;
      logic [SEC_W-1:0]  seconds;
   } clock_time_t;

   // Single definition of the timekeeper freeze condition.
   function automatic logic setter_hold(input logic [1:0] setter_state);
      return setter_state != SET_INITIAL;
   endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-per-second tick. The counter runs 0..TICKS_PER_SEC-1
// while enabled, freezes mid-count when disabled, and restarts from 0 on clear.
module sec_prescaler #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = $clog2(TICKS_PER_SEC);
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TICKS_PER_SEC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = enable && !clear && (cnt_q == TERM_CNT);

   // Next count: clear wins, then wrap at terminal count, else increment while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == TERM_CNT) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/time_keeper_12h.sv
// Running 12-hour time-of-day counter. Loads a committed setting on the
// propagate strobe (rejecting out-of-range values), otherwise advances one
// second per prescaler tick with a seconds->minutes->hours->AM/PM carry chain.
// Freezes, keeping the partial second, while hold is high.
module time_keeper_12h
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              propagate,
   input  logic              load_pm,
   input  logic [HOUR_W-1:0] load_hours,
   input  logic [MIN_W-1:0]  load_minutes,
   input  logic              hold,
   output logic              isPM,
   output logic [HOUR_W-1:0] hours,
   output logic [MIN_W-1:0]  minutes,
   output logic [SEC_W-1:0]  seconds,
   output logic              sec_tick,
   output logic              load_err
);

   localparam logic [HOUR_W-1:0] HOUR_PRE_NOON = HOUR_W'(HOUR_MAX - 4'd1);

   clock_time_t time_q, time_d;
   logic        sec_tick_q, sec_tick_d;
   logic        load_err_q, load_err_d;
   logic        load_ok;
   logic        pre_tick;

   assign load_ok = (load_hours >= HOUR_MIN) && (load_hours <= HOUR_MAX) &&
                    (load_minutes <= MIN_MAX);

   // Prescaler restarts only on an accepted load; it runs only when neither
   // a load nor a hold is present, so a load on the terminal-count cycle
   // suppresses that tick.
   sec_prescaler #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_sec_prescaler (
      .clk    (clk),
      .reset  (reset),
      .clear  (propagate && load_ok),
      .enable (!propagate && !hold),
      .tick   (pre_tick)
   );

   // Next time: load has priority over the second advance and its carry chain.
   always_comb begin
      time_d     = time_q;
      sec_tick_d = 1'b0;
      load_err_d = 1'b0;
      if (propagate) begin
         if (load_ok) begin
            time_d.is_pm   = load_pm;
            time_d.hours   = load_hours;
            time_d.minutes = load_minutes;
            time_d.seconds = '0;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (pre_tick) begin
         sec_tick_d = 1'b1;
         if (time_q.seconds == SEC_MAX) begin
            time_d.seconds = '0;
            if (time_q.minutes == MIN_MAX) begin
               time_d.minutes = '0;
               if (time_q.hours == HOUR_MAX) begin
                  time_d.hours = HOUR_MIN;
               end else begin
                  time_d.hours = time_q.hours + HOUR_W'(1);
                  if (time_q.hours == HOUR_PRE_NOON) begin
                     time_d.is_pm = !time_q.is_pm;
                  end
               end
            end else begin
               time_d.minutes = time_q.minutes + MIN_W'(1);
            end
         end else begin
            time_d.seconds = time_q.seconds + SEC_W'(1);
         end
      end
   end

   // State registers; reset lands on 12:00:00 AM.
   always_ff @(posedge clk) begin
      if (!reset) begin
         time_q.is_pm   <= 1'b0;
         time_q.hours   <= HOUR_MAX;
         time_q.minutes <= '0;
         time_q.seconds <= '0;
         sec_tick_q     <= 1'b0;
         load_err_q     <= 1'b0;
      end else begin
         time_q     <= time_d;
         sec_tick_q <= sec_tick_d;
         load_err_q <= load_err_d;
      end
   end

   assign isPM     = time_q.is_pm;
   assign hours    = time_q.hours;
   assign minutes  = time_q.minutes;
   assign seconds  = time_q.seconds;
   assign sec_tick = sec_tick_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_time_keeper_12h.sv
// Directed bench for time_keeper_12h with TICKS_PER_SEC=4. A reference model
// keeps time as seconds since midnight; each driven cycle pushes the model's
// expected outputs into a queue that is popped and compared after the edge.
module tb_time_keeper_12h;

   localparam int TPS = 4;

   typedef struct packed {
      logic       pm;
      logic [3:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic       tk;
      logic       er;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       propagate;
   logic       load_pm;
   logic [3:0] load_hours;
   logic [5:0] load_minutes;
   logic       hold;
   logic       isPM;
   logic [3:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       sec_tick;
   logic       load_err;

   int   n_cmp  = 0;
   int   n_fail = 0;
   obs_t exp_q[$];

   // reference model state
   int   m_t   = 0;
   int   m_pre = 0;
   logic m_tk  = 1'b0;
   logic m_er  = 1'b0;
   int   n_ticks = 0;

   time_keeper_12h #(.TICKS_PER_SEC(TPS)) dut (
      .clk          (clk),
      .reset        (reset),
      .propagate    (propagate),
      .load_pm      (load_pm),
      .load_hours   (load_hours),
      .load_minutes (load_minutes),
      .hold         (hold),
      .isPM         (isPM),
      .hours        (hours),
      .minutes      (minutes),
      .seconds      (seconds),
      .sec_tick     (sec_tick),
      .load_err     (load_err)
   );

   always #5 clk = ~clk;

   function automatic obs_t model_obs();
      obs_t o;
      int   h24;
      h24  = m_t / 3600;
      o.pm = (h24 >= 12);
      o.h  = 4'((h24 % 12 == 0) ? 12 : h24 % 12);
      o.m  = 6'((m_t / 60) % 60);
      o.s  = 6'(m_t % 60);
      o.tk = m_tk;
      o.er = m_er;
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("pm=%0d %0d:%0d:%0d tick=%0d err=%0d", o.pm, o.h, o.m, o.s, o.tk, o.er);
   endfunction

   task automatic check_val(input string tag, input int obs, input int expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive inputs, advance model, push expectation, compare after edge.
   task automatic step(input logic rst, input logic prop, input logic lp, input int lh,
                       input int lm, input logic hld, input string tag);
      obs_t got, e;
      reset        = rst;
      propagate    = prop;
      load_pm      = lp;
      load_hours   = 4'(lh);
      load_minutes = 6'(lm);
      hold         = hld;
      m_tk = 1'b0;
      m_er = 1'b0;
      if (!rst) begin
         m_t   = 0;
         m_pre = 0;
      end else if (prop) begin
         if (lh >= 1 && lh <= 12 && lm <= 59) begin
            m_t   = ((lh % 12) + (lp ? 12 : 0)) * 3600 + lm * 60;
            m_pre = 0;
         end else begin
            m_er = 1'b1;
         end
      end else if (!hld) begin
         if (m_pre == TPS - 1) begin
            m_pre = 0;
            m_t   = (m_t + 1) % 86400;
            m_tk  = 1'b1;
         end else begin
            m_pre++;
         end
      end
      exp_q.push_back(model_obs());
      @(posedge clk);
      #1;
      got = '{isPM, hours, minutes, seconds, sec_tick, load_err};
      if (got.tk === 1'b1) n_ticks++;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed %s with empty scoreboard", tag, fmt(got));
      end else begin
         e = exp_q.pop_front();
         assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: observed %s expected %s", tag, fmt(got), fmt(e));
         end
      end
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, tag);
   endtask

   task automatic load(input logic lp, input int lh, input int lm, input logic hld, input string tag);
      step(1'b1, 1'b1, lp, lh, lm, hld, tag);
   endtask

   initial begin
      reset = 1'b0; propagate = 1'b0; load_pm = 1'b0;
      load_hours = '0; load_minutes = '0; hold = 1'b0;

      // reset for two cycles, then first tick four edges later
      step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, "reset0");
      step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, "reset1");
      run(3, "post_reset");
      check_val("no_tick_before_4", n_ticks, 0);
      run(1, "first_tick");
      check_val("first_tick_sec", seconds, 1);
      run(8, "post_reset_run");

      // noon rollover
      load(1'b0, 11, 59, 1'b0, "load_1159am");
      n_ticks = 0;
      run(240, "noon_roll");
      check_val("noon_ticks", n_ticks, 60);
      check_val("noon_hours", hours, 12);
      check_val("noon_pm", isPM, 1);

      // 12 -> 1 keeps PM, then midnight rollover
      load(1'b1, 12, 59, 1'b0, "load_1259pm");
      run(240, "one_pm");
      check_val("one_pm_hours", hours, 1);
      check_val("one_pm_pm", isPM, 1);
      load(1'b1, 11, 59, 1'b0, "load_1159pm");
      run(240, "midnight");
      check_val("midnight_hours", hours, 12);
      check_val("midnight_pm", isPM, 0);

      // rejected loads
      run(5, "pre_reject");
      load(1'b1, 13, 10, 1'b0, "reject_h13");
      check_val("err_h13", load_err, 1);
      run(1, "between_rejects");
      load(1'b0, 5, 60, 1'b0, "reject_m60");
      check_val("err_m60", load_err, 1);
      load(1'b0, 0, 30, 1'b0, "reject_h0");
      run(6, "post_reject");

      // hold at prescaler == 2
      for (int i = 0; i < TPS && m_pre != 2; i++) run(1, "to_pre2");
      n_ticks = 0;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, "hold");
      check_val("hold_no_tick", n_ticks, 0);
      run(1, "release1");
      check_val("release_no_tick_yet", n_ticks, 0);
      run(1, "release2");
      check_val("release_tick", n_ticks, 1);

      // load during hold
      run(1, "pre_hold_load");
      step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, "hold_a");
      load(1'b1, 3, 7, 1'b1, "hold_load_307pm");
      check_val("hold_load_h", hours, 3);
      check_val("hold_load_m", minutes, 7);
      step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, "hold_b");
      run(6, "after_hold_load");

      // propagate on terminal count
      for (int i = 0; i < TPS && m_pre != TPS - 1; i++) run(1, "to_term");
      load(1'b0, 7, 30, 1'b0, "load_on_tc");
      check_val("tc_load_tick", sec_tick, 0);
      check_val("tc_load_sec", seconds, 0);
      run(6, "after_tc_load");

      // reset wins over propagate
      step(1'b0, 1'b1, 1'b1, 5, 5, 1'b0, "reset_and_prop");
      check_val("rst_prop_hours", hours, 12);
      run(6, "after_reset_prop");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/time_keeper_12h.md
# time_keeper_12h

Running 12-hour time-of-day counter that consumes the committed setting produced by the clock-setting FSM. It loads hours, minutes and AM/PM on the setter's one-cycle `propagate` strobe, then advances seconds, minutes, hours and AM/PM from a prescaled system clock. Its outputs feed the display and alarm-compare logic. It freezes while the setter is mid-edit.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: `clk` cycles per second, ≥ 2.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `propagate`  in  1: one-cycle load strobe from the setter.
- `load_pm`  in  1: AM/PM value to load (1 = PM).
- `load_hours`  in  4: hours to load, valid 1..12.
- `load_minutes`  in  6: minutes to load, valid 0..59.
- `hold`  in  1: freeze timekeeping (setter state ≠ INITIAL).
- `isPM`  out  1: current AM/PM.
- `hours`  out  4: current hour, 1..12.
- `minutes`  out  6: current minute, 0..59.
- `seconds`  out  6: current second, 0..59.
- `sec_tick`  out  1: one-cycle pulse on each second advance.
- `load_err`  out  1: one-cycle pulse when a load was rejected.

## Operation
- All outputs are registered.
- Reset values: `isPM`=0, `hours`=12, `minutes`=0, `seconds`=0, `sec_tick`=0, `load_err`=0, prescaler=0.
- Priority per edge: reset, then propagate, then hold, then run.
- Load (`propagate`=1):
  - Valid when `load_hours` is 1..12 and `load_minutes` ≤ 59.
  - Valid load: copy the three inputs, set `seconds`=0, prescaler=0, `sec_tick`=0.
  - Invalid load: time and prescaler unchanged; `load_err`=1 for one cycle.
  - Load applies even while `hold`=1.
- Hold (`hold`=1, no propagate): prescaler and time frozen; `sec_tick`=0.
- Run:
  - Prescaler counts 0..TICKS_PER_SEC-1.
  - At terminal count, prescaler returns to 0 and the second advances on the same edge, with `sec_tick`=1.
- Second-advance carry chain, all on one edge:
  - `seconds` 59→0 carries into minutes.
  - `minutes` 59→0 carries into hours.
  - `hours` 11→12 toggles `isPM`.
  - `hours` 12→1 leaves `isPM` unchanged.
  - Otherwise `hours`+1.
- Arithmetic is unsigned at the port widths. Out-of-range values are unreachable except by a rejected load.

## Timing
- Load latency is 1 cycle: values are visible the cycle after the `propagate` edge.
- After a valid load or a reset release at edge k with `hold`=0, the first `sec_tick` and second advance occur at edge k+TICKS_PER_SEC. They repeat every TICKS_PER_SEC cycles.
- Hold pauses the prescaler mid-count. On release, counting resumes from the held prescaler value, so the partial second is preserved.
- `propagate` coincident with the prescaler terminal count: the load wins and no tick occurs.
- Reset is sampled only at a `clk` edge. Reset low mid-count restores the reset values on that edge, regardless of `propagate`.

## Structure
- Shared package `clock_pkg` holds:
  - `HOUR_MIN`=1, `HOUR_MAX`=12, `MIN_MAX`=59, `SEC_MAX`=59.
  - Widths: `HOUR_W`=4, `MIN_W`=6, `SEC_W`=6.
  - The setter's state encoding (INITIAL/PM/HOUR/MINUTE), so the `hold` derivation shares one definition.
- Sub-module `sec_prescaler`:
  - Parameter `TICKS_PER_SEC`; inputs `clear`, `enable`; output `tick`.
  - Counter width is `$clog2(TICKS_PER_SEC)`.
- The carry chain and load logic stay in the top module.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset: hold `reset`=0 for 2 cycles, then release → 12:00:00, `isPM`=0. The first `sec_tick` comes 4 cycles after release, then `seconds`=1.
- Noon rollover: load 11:59 AM, run 240 cycles → 12:00:00, `isPM`=1, with exactly 60 `sec_tick` pulses.
- Hour wrap: load 12:59 PM, run 240 cycles → 1:00:00, `isPM` still 1. Continue to 11:59:59 PM and advance one second → 12:00:00, `isPM`=0.
- Rejected load: `propagate` with `load_hours`=13, then again with `load_minutes`=60 → time unchanged, `load_err` pulses once for each.
- Hold:
  - Raise `hold` at prescaler=2 for 10 cycles → no change, no `sec_tick`.
  - After release, the tick arrives 2 cycles later.
  - `propagate` during hold loads 3:07 PM and shows it on the next cycle.
- Simultaneous events:
  - `propagate` on the terminal-count cycle → loaded value with `seconds`=0, no tick.
  - `reset`=0 together with `propagate` → reset values.
